transducer_drive: RTL and testbench
===================================

// Module: transducer_drive
// PURPOSE
//  Downstream consumer of the modulation gate (mod_out). Generates NUM_CHANNELS phase-shifted
//  square waves, one per ultrasonic transducer, from a free-running carrier counter.
//  The modulation gate is applied only on carrier-period boundaries, so no runt pulses occur.
//  Phases are double-buffered: host writes shadow regs, commit swaps them at the next wrap.
// PARAMETERS
//  NUM_CHANNELS  8    number of transducer outputs
//  PERIOD        256  clk cycles per carrier period (10.24 MHz / 256 = 40 kHz); power of 2, >=4
//  PHASE_W       8    phase word width; must equal log2(PERIOD)
//  ADDR_W        3    channel address width; 2**ADDR_W >= NUM_CHANNELS
// PORTS
//  clk             in   1             system clock
//  rst_n           in   1             asynchronous active-low reset
//  mod_in          in   1             modulation gate from modulation block (1 = drive on)
//  phase_wr_en     in   1             write phase_wr_data to shadow[phase_wr_addr]
//  phase_wr_addr   in   ADDR_W        channel index
//  phase_wr_data   in   PHASE_W       phase offset in carrier counts
//  phase_commit    in   1             request shadow->active copy at next carrier wrap
//  duty_high       in   PHASE_W       high-time in counts (present only with DUTY_CTRL_EN)
//  drive_out       out  NUM_CHANNELS  transducer drive, registered
//  period_tick     out  1             1-cycle pulse on the cycle carrier counter == 0
//  commit_pending  out  1             commit requested, not yet applied
// BEHAVIOUR
//  Reset (async assert, sync release): counter=0, shadow[*]=0, active[*]=0, gate=0,
//   drive_out=0, period_tick=0, commit_pending=0.
//  Counter: cnt increments each clk, PERIOD-1 -> 0 wrap (PHASE_W-bit natural overflow).
//  wrap event = (cnt == PERIOD-1); on that edge:
//   - gate <= mod_in (mod_in sampled only here; changes mid-period are ignored)
//   - if commit_pending or phase_commit: active[*] <= shadow[*] (including a same-cycle write),
//     commit_pending <= 0
//  Otherwise phase_commit sets commit_pending <= 1; repeated commits while pending are merged.
//  Shadow write: phase_wr_en captures data at the edge; addr >= NUM_CHANNELS ignored, no side effect.
//  Per channel: rel_i = (cnt - active[i]) mod PERIOD (PHASE_W-bit subtract, wrap discarded).
//   drive_out[i] <= gate & (rel_i < HIGH), HIGH = PERIOD/2 (default build).
//  Latency: drive_out reflects cnt value of previous cycle (1-cycle register).
//  period_tick <= (cnt == PERIOD-1), so it is high while cnt == 0.
//  Gate off: all outputs 0 from the first cycle of the next period, held through full periods.
//  Active phases never change mid-period; a period always uses one consistent phase set.
//  Reset mid-operation: outputs drop to 0 immediately (async); pending commit discarded.
// CONFIGURATION
//  DUTY_CTRL_EN defined: duty_high port exists; HIGH = duty_high, latched on the wrap event
//   together with gate. duty_high=0 -> outputs stay 0; duty_high>=PERIOD-1 saturates at PERIOD-1.
//  DUTY_CTRL_EN undefined: no duty_high port; HIGH fixed at PERIOD/2 (50 % duty).
// TESTING
//  1 Reset release, mod_in=1, phases 0 -> first gated period starts at cnt=0;
//    drive_out=8'hFF for cycles 1..128 after tick, 0 for 129..256.
//  2 Write ch3 phase=64, commit -> ch3 rises 64 cycles after ch0 from next period only;
//    commit_pending high until that wrap.
//  3 Commit and write ch1=32 in the same cycle as cnt==255 -> ch1 shifted by 32
//    in the immediately following period; commit_pending never asserts.
//  4 Drop mod_in at cnt=100 -> current period completes unchanged;
//    next period all outputs 0; restore at cnt=10 -> resumes at next wrap.
//  5 Write addr=7 with NUM_CHANNELS=6 -> no shadow/active change;
//    assert rst_n=0 mid-period -> drive_out=0 same cycle, counter restarts at 0.
//  6 DUTY_CTRL_EN, duty_high=64 -> ch0 high 64 of 256 cycles;
//    duty_high=0 -> flat 0; duty_high=255 -> high 255 cycles.

Source files
------------

// File: rtl/transducer_drive.sv
// Phase-shifted square-wave drive for an ultrasonic transducer array, gated per carrier period.
// Optional build macro DUTY_CTRL_EN adds a duty_high port that sets the high time of each period.
module transducer_drive #(
    parameter int NUM_CHANNELS = 8,
    parameter int PERIOD       = 256,
    parameter int PHASE_W      = 8,
    parameter int ADDR_W       = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mod_in,
    input  logic                    phase_wr_en,
    input  logic [ADDR_W-1:0]       phase_wr_addr,
    input  logic [PHASE_W-1:0]      phase_wr_data,
    input  logic                    phase_commit,
`ifdef DUTY_CTRL_EN
    input  logic [PHASE_W-1:0]      duty_high,
`endif
    output logic [NUM_CHANNELS-1:0] drive_out,
    output logic                    period_tick,
    output logic                    commit_pending
);

    localparam logic [PHASE_W-1:0] LAST = PHASE_W'(PERIOD - 1);
    localparam logic [PHASE_W-1:0] HALF = PHASE_W'(PERIOD / 2);

    logic [PHASE_W-1:0]      cnt;
    logic                    wrap;
    logic                    gate;
    logic [PHASE_W-1:0]      high;
    logic [PHASE_W-1:0]      shadow      [NUM_CHANNELS];
    logic [PHASE_W-1:0]      active      [NUM_CHANNELS];
    logic [PHASE_W-1:0]      shadow_next [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] drive_next;

    assign wrap = (cnt == LAST);

`ifdef DUTY_CTRL_EN
    logic [PHASE_W-1:0] high_r;
    assign high = high_r;
`else
    assign high = HALF;
`endif

    // The shadow view seen by a commit includes a write landing on the same edge.
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            shadow_next[i] = shadow[i];
            if (phase_wr_en && phase_wr_addr == ADDR_W'(i))
                shadow_next[i] = phase_wr_data;
        end
    end

    // Offset from the channel's phase, wrapped modulo the carrier period.
    always_comb begin
        drive_next = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            logic [PHASE_W-1:0] rel;
            rel           = cnt - active[i];
            drive_next[i] = gate && (rel < high);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= '0;
            gate           <= 1'b0;
            commit_pending <= 1'b0;
            period_tick    <= 1'b0;
            drive_out      <= '0;
`ifdef DUTY_CTRL_EN
            high_r         <= '0;
`endif
            // NOTE: the phase arrays are small flop banks and must come up as zero, so they are reset.
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            cnt         <= cnt + PHASE_W'(1);
            period_tick <= wrap;
            drive_out   <= drive_next;
            for (int i = 0; i < NUM_CHANNELS; i++)
                shadow[i] <= shadow_next[i];

            if (wrap) begin
                gate           <= mod_in;
                commit_pending <= 1'b0;
`ifdef DUTY_CTRL_EN
                high_r         <= (duty_high >= LAST) ? LAST : duty_high;
`endif
                if (commit_pending || phase_commit) begin
                    for (int i = 0; i < NUM_CHANNELS; i++)
                        active[i] <= shadow_next[i];
                end
            end else if (phase_commit) begin
                commit_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_transducer_drive.sv
// Directed bench for transducer_drive: a full 8-channel instance plus a 6-channel instance
// used for out-of-range address writes. DUTY_CTRL_EN enables the duty-cycle scenario.
module tb_transducer_drive;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mod_in, wr_en, commit;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] drive_out;
    logic       period_tick, commit_pending;

    logic       mod6, wr6_en, commit6;
    logic [2:0] wr6_addr;
    logic [7:0] wr6_data;
    logic [5:0] drive6;
    logic       tick6, pend6;

`ifdef DUTY_CTRL_EN
    logic [7:0] duty_high, duty6;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] tr_drv  [256];
    logic [5:0] tr_drv6 [256];
    logic       tr_pend [256];
    logic       tr_tick_end;

    always #5 clk = ~clk;

    transducer_drive #(.NUM_CHANNELS(8), .PERIOD(256), .PHASE_W(8), .ADDR_W(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .mod_in(mod_in), .phase_wr_en(wr_en),
        .phase_wr_addr(wr_addr), .phase_wr_data(wr_data), .phase_commit(commit),
`ifdef DUTY_CTRL_EN
        .duty_high(duty_high),
`endif
        .drive_out(drive_out), .period_tick(period_tick), .commit_pending(commit_pending)
    );

    transducer_drive #(.NUM_CHANNELS(6), .PERIOD(256), .PHASE_W(8), .ADDR_W(3)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .mod_in(mod6), .phase_wr_en(wr6_en),
        .phase_wr_addr(wr6_addr), .phase_wr_data(wr6_data), .phase_commit(commit6),
`ifdef DUTY_CTRL_EN
        .duty_high(duty6),
`endif
        .drive_out(drive6), .period_tick(tick6), .commit_pending(pend6)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got stuck, required completion");
        $fatal(1, "watchdog");
    end

    // Expected waveform: sample j reflects carrier count j.
    function automatic int errs8(input int ch, input int p, input logic g, input int h);
        int e = 0;
        for (int j = 0; j < 256; j++) begin
            int   rel = (j - p) & 255;
            logic exp = g && (rel < h);
            if (tr_drv[j][ch] !== exp) e++;
        end
        return e;
    endfunction

    function automatic int errs6(input int ch, input int p, input logic g, input int h);
        int e = 0;
        for (int j = 0; j < 256; j++) begin
            int   rel = (j - p) & 255;
            logic exp = g && (rel < h);
            if (tr_drv6[j][ch] !== exp) e++;
        end
        return e;
    endfunction

    function automatic int pend_ones();
        int n = 0;
        for (int j = 0; j < 256; j++) if (tr_pend[j] !== 1'b0) n++;
        return n;
    endfunction

    // Wait for the next tick, then step to the first sample of that period.
    task automatic sync_period();
        int n = 0;
        while (period_tick !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (period_tick !== 1'b1) begin
            bad++;
            $display("FAIL sync_tick: period_tick=%b after %0d cycles, required 1", period_tick, n);
        end
        @(negedge clk);
    endtask

    // Record one carrier period starting at the sample that reflects cnt=0; the input
    // actions at index j are applied in the cycle where cnt=j+1.
    task automatic capture(input int mod_at, input logic mod_val, input int wr_at,
                           input int wa, input int wd, input int commit_at);
        for (int j = 0; j < 256; j++) begin
            tr_drv[j]  = drive_out;
            tr_drv6[j] = drive6;
            tr_pend[j] = commit_pending;
            if (j == 255) tr_tick_end = period_tick;
            wr_en  = (j == wr_at);
            commit = (j == commit_at);
            if (j == wr_at) begin
                wr_addr = 3'(wa);
                wr_data = 8'(wd);
            end
            if (j == mod_at) mod_in = mod_val;
            @(negedge clk);
        end
        wr_en  = 1'b0;
        commit = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mod_in = 1'b0; wr_en = 1'b0; commit = 1'b0; wr_addr = '0; wr_data = '0;
        mod6 = 1'b0; wr6_en = 1'b0; commit6 = 1'b0; wr6_addr = '0; wr6_data = '0;
`ifdef DUTY_CTRL_EN
        duty_high = 8'd128;
        duty6     = 8'd128;
`endif
        repeat (3) @(negedge clk);
        total++; if (drive_out !== 8'h00) begin bad++; $display("FAIL reset_drive: got %h want 00", drive_out); end
        total++; if (period_tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", period_tick); end
        total++; if (commit_pending !== 1'b0) begin bad++; $display("FAIL reset_pending: got %b want 0", commit_pending); end
        total++; if (drive6 !== 6'h00) begin bad++; $display("FAIL reset_drive6: got %h want 00", drive6); end
    endtask

    task automatic test_first_period();
        int n = 0;
        mod_in = 1'b1;
        mod6   = 1'b1;
        rst_n  = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (period_tick !== 1'b1 && n < 300);
        total++; if (n !== 256) begin bad++; $display("FAIL first_tick: after %0d cycles, want 256", n); end
        @(negedge clk);
        capture(-1, 1'b0, -1, 0, 0, -1);
        for (int ch = 0; ch < 8; ch++) begin
            int e = errs8(ch, 0, 1'b1, 128);
            total++; if (e !== 0) begin bad++; $display("FAIL first_ch%0d: %0d wrong samples, want 0", ch, e); end
        end
        total++; if (tr_drv[0] !== 8'hFF) begin bad++; $display("FAIL first_s1: got %h want FF", tr_drv[0]); end
        total++; if (tr_drv[127] !== 8'hFF) begin bad++; $display("FAIL first_s128: got %h want FF", tr_drv[127]); end
        total++; if (tr_drv[128] !== 8'h00) begin bad++; $display("FAIL first_s129: got %h want 00", tr_drv[128]); end
        total++; if (tr_drv[255] !== 8'h00) begin bad++; $display("FAIL first_s256: got %h want 00", tr_drv[255]); end
        total++; if (tr_tick_end !== 1'b1) begin bad++; $display("FAIL first_tick_end: got %b want 1", tr_tick_end); end
    endtask

    task automatic test_commit();
        int e;
        capture(-1, 1'b0, 5, 3, 64, 10);
        e = errs8(3, 0, 1'b1, 128);
        total++; if (e !== 0) begin bad++; $display("FAIL commit_old_ch3: %0d wrong samples, want 0", e); end
        total++; if (tr_pend[10] !== 1'b0) begin bad++; $display("FAIL commit_pend_before: got %b want 0", tr_pend[10]); end
        total++; if (tr_pend[11] !== 1'b1) begin bad++; $display("FAIL commit_pend_set: got %b want 1", tr_pend[11]); end
        total++; if (tr_pend[254] !== 1'b1) begin bad++; $display("FAIL commit_pend_hold: got %b want 1", tr_pend[254]); end
        total++; if (tr_pend[255] !== 1'b0) begin bad++; $display("FAIL commit_pend_clear: got %b want 0", tr_pend[255]); end
        capture(-1, 1'b0, -1, 0, 0, -1);
        e = errs8(3, 64, 1'b1, 128);
        total++; if (e !== 0) begin bad++; $display("FAIL commit_new_ch3: %0d wrong samples, want 0", e); end
        e = errs8(0, 0, 1'b1, 128);
        total++; if (e !== 0) begin bad++; $display("FAIL commit_new_ch0: %0d wrong samples, want 0", e); end
    endtask

    task automatic test_commit_at_wrap();
        int e;
        capture(-1, 1'b0, 254, 1, 32, 254);
        e = errs8(1, 0, 1'b1, 128);
        total++; if (e !== 0) begin bad++; $display("FAIL wrapc_old_ch1: %0d wrong samples, want 0", e); end
        e = pend_ones();
        total++; if (e !== 0) begin bad++; $display("FAIL wrapc_pend_a: %0d samples high, want 0", e); end
    endtask

    task automatic test_gate();
        int e;
        capture(99, 1'b0, -1, 0, 0, -1);
        e = errs8(1, 32, 1'b1, 128);
        total++; if (e !== 0) begin bad++; $display("FAIL wrapc_new_ch1: %0d wrong samples, want 0", e); end
        e = errs8(3, 64, 1'b1, 128);
        total++; if (e !== 0) begin bad++; $display("FAIL gate_full_ch3: %0d wrong samples, want 0", e); end
        e = pend_ones();
        total++; if (e !== 0) begin bad++; $display("FAIL wrapc_pend_b: %0d samples high, want 0", e); end
        capture(9, 1'b1, -1, 0, 0, -1);
        for (int ch = 0; ch < 8; ch++) begin
            e = errs8(ch, 0, 1'b0, 128);
            total++; if (e !== 0) begin bad++; $display("FAIL gate_off_ch%0d: %0d wrong samples, want 0", ch, e); end
        end
        capture(-1, 1'b0, -1, 0, 0, -1);
        e = errs8(0, 0, 1'b1, 128) + errs8(1, 32, 1'b1, 128) + errs8(3, 64, 1'b1, 128);
        total++; if (e !== 0) begin bad++; $display("FAIL gate_resume: %0d wrong samples, want 0", e); end
    endtask

    task automatic test_bad_addr_and_reset();
        int e;
        int n = 0;
        wr6_en = 1'b1; wr6_addr = 3'd7; wr6_data = 8'd50; commit6 = 1'b1;
        @(negedge clk);
        wr6_en = 1'b0; commit6 = 1'b0;
        total++; if (pend6 !== 1'b1) begin bad++; $display("FAIL addr_pend6: got %b want 1", pend6); end
        sync_period();
        capture(-1, 1'b0, -1, 0, 0, -1);
        for (int ch = 0; ch < 6; ch++) begin
            e = errs6(ch, 0, 1'b1, 128);
            total++; if (e !== 0) begin bad++; $display("FAIL addr_ch%0d: %0d wrong samples, want 0", ch, e); end
        end
        total++; if (pend6 !== 1'b0) begin bad++; $display("FAIL addr_pend6_clear: got %b want 0", pend6); end

        // Reset in the middle of a gated period with a commit outstanding.
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        total++; if (commit_pending !== 1'b1) begin bad++; $display("FAIL mid_pend: got %b want 1", commit_pending); end
        repeat (48) @(negedge clk);
        total++; if (drive_out !== 8'hF7) begin bad++; $display("FAIL mid_drive: got %h want F7", drive_out); end
        rst_n = 1'b0;
        #1;
        total++; if (drive_out !== 8'h00) begin bad++; $display("FAIL mid_rst_drive: got %h want 00", drive_out); end
        total++; if (commit_pending !== 1'b0) begin bad++; $display("FAIL mid_rst_pend: got %b want 0", commit_pending); end
        @(negedge clk);
        rst_n = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (period_tick !== 1'b1 && n < 300);
        total++; if (n !== 256) begin bad++; $display("FAIL mid_restart: tick after %0d cycles, want 256", n); end
        @(negedge clk);
        capture(-1, 1'b0, -1, 0, 0, -1);
        e = errs8(1, 0, 1'b1, 128) + errs8(3, 0, 1'b1, 128) + errs8(0, 0, 1'b1, 128);
        total++; if (e !== 0) begin bad++; $display("FAIL mid_phases_cleared: %0d wrong samples, want 0", e); end
        e = pend_ones();
        total++; if (e !== 0) begin bad++; $display("FAIL mid_pend_after: %0d samples high, want 0", e); end
    endtask

`ifdef DUTY_CTRL_EN
    task automatic test_duty();
        int e;
        duty_high = 8'd64;
        sync_period();
        duty_high = 8'd0;
        capture(-1, 1'b0, -1, 0, 0, -1);
        e = errs8(0, 0, 1'b1, 64);
        total++; if (e !== 0) begin bad++; $display("FAIL duty64: %0d wrong samples, want 0", e); end
        duty_high = 8'd255;
        capture(-1, 1'b0, -1, 0, 0, -1);
        e = errs8(0, 0, 1'b1, 0);
        total++; if (e !== 0) begin bad++; $display("FAIL duty0: %0d wrong samples, want 0", e); end
        capture(-1, 1'b0, -1, 0, 0, -1);
        e = errs8(0, 0, 1'b1, 255);
        total++; if (e !== 0) begin bad++; $display("FAIL duty255: %0d wrong samples, want 0", e); end
    endtask
`endif

    initial begin
        test_reset();
        test_first_period();
        test_commit();
        test_commit_at_wrap();
        test_gate();
        test_bad_addr_and_reset();
`ifdef DUTY_CTRL_EN
        test_duty();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
